// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_CLK_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to 1 (line idle).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronised rx, mid-bit sampling, one-cycle new_data strobe per valid frame.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data
);

  localparam int unsigned CTR_W   = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_W   = $clog2(UART_DATA_BITS);
  localparam int unsigned HALF_M1 = (CLK_PER_BIT / 2) - 1;
  localparam int unsigned FULL_M1 = CLK_PER_BIT - 1;

  logic                      rx_s;
  uart_rx_state_e            state, state_d;
  logic [CTR_W-1:0]          ctr, ctr_d;
  logic [IDX_W-1:0]          bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg, shreg_d;
  logic [7:0]                data_d;
  logic                      new_data_d;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ctr      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      data     <= 8'h00;
      new_data <= 1'b0;
    end else begin
      state    <= state_d;
      ctr      <= ctr_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      data     <= data_d;
      new_data <= new_data_d;
    end
  end

  // Next-state: the bit timer wraps to 0 at every sample point.
  always_comb begin
    state_d    = state;
    ctr_d      = ctr;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    data_d     = data;
    new_data_d = 1'b0;

    case (state)
      IDLE: begin
        ctr_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (ctr == CTR_W'(HALF_M1)) begin
          ctr_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          ctr_d = ctr + CTR_W'(1);
        end
      end

      DATA: begin
        if (ctr == CTR_W'(FULL_M1)) begin
          ctr_d            = '0;
          shreg_d[bit_idx] = rx_s;
          bit_idx_d        = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) state_d = STOP;
        end else begin
          ctr_d = ctr + CTR_W'(1);
        end
      end

      STOP: begin
        if (ctr == CTR_W'(FULL_M1)) begin
          ctr_d = '0;
          if (rx_s) begin
            data_d     = shreg;
            new_data_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else begin
          ctr_d = ctr + CTR_W'(1);
        end
      end

      // Framing error or break: hold off until the line returns high.
      WAIT_IDLE: begin
        ctr_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        ctr_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: expected bytes and start cycles queued at stimulus, checked on strobe.
module tb_uart_rx_byte;

  localparam int unsigned BIT_CLKS = 434;
  localparam int unsigned LAT_CLKS = (BIT_CLKS * 19) / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       new_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_rx_byte #(.CLK_PER_BIT(BIT_CLKS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .new_data (new_data)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Called on a falling clk edge; drives one full 8N1 frame.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic expect_v);
    if (expect_v) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_v);
  endtask

  // Output monitor: strobe contents, latency, single-cycle strobe, data held between strobes.
  always begin : mon
    logic [7:0] prev_data;
    logic       prev_nd;
    logic [7:0] e;
    int         s;
    prev_data = 8'h00;
    prev_nd   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_data = data;
        prev_nd   = 1'b0;
      end else begin
        if (new_data) begin
          chk("nd_single", 32'(prev_nd), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexp_pulse", 32'(new_data), 32'd0);
          end else begin
            e = exp_q.pop_front();
            s = start_q.pop_front();
            chk("rx_byte", 32'(data), 32'(e));
            chk("latency", 32'(cyc - s), 32'(LAT_CLKS));
          end
        end else if (data !== prev_data) begin
          chk("data_hold", 32'(data), 32'(prev_data));
        end
        prev_data = data;
        prev_nd   = new_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset and idle line.
    rst = 1'b0;
    rx  = 1'b1;
    #100;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_nd", 32'(new_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_data", 32'(data), 32'h00);
    chk("idle_nd", 32'(new_data), 32'd0);

    // Single frames with idle gaps.
    send_byte(8'h11, 1'b1, 1'b1);
    repeat (1000) @(negedge clk);
    chk("held_11", 32'(data), 32'h11);
    send_byte(8'h55, 1'b1, 1'b1);
    chk("sb_55", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames.
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("b2b_last", 32'(data), 32'h3C);

    // Short glitch on idle line.
    rx = 1'b0;
    repeat (150) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    chk("glitch_data", 32'(data), 32'h3C);

    // Framing error, then recovery.
    send_byte(8'h5A, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    chk("ferr_data", 32'(data), 32'h3C);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    send_byte(8'h7E, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    chk("after_ferr", 32'(data), 32'h7E);

    // Reset in the middle of the data bits.
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    repeat (200) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_nd", 32'(new_data), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk("post_rst_data", 32'(data), 32'h00);
    send_byte(8'hC3, 1'b1, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    chk("final_data", 32'(data), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
